dht11_emulador: RTL and testbench

Open-drain responder for the DHT11 single-wire protocol. It is the sensor side of the bus that our DHT11 interface drives as initiator. It waits for a host start pulse on `dht_bus`, then returns a 40-bit humidity/temperature frame with checksum, using DHT11 bit timing. It is used for board-level loopback of the climate controller without a physical sensor, and as the bus model in system benches.

---
 rtl/dht11_pkg.sv | 27 ++
 rtl/dht11_emulador_sincronizador.sv | 30 +++
 rtl/dht11_emulador.sv | 102 ++++++++++
 tb/tb_dht11_emulador.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared states, phase lengths and checksum helper for the DHT11 emulator and host interface.
package dht11_pkg;
   typedef enum logic [3:0] {
      AGUARDA        = 4'd0,
      MEDE_START     = 4'd1,
      AGUARDA_LIBERA = 4'd2,
      ESPERA         = 4'd3,
      RESP_BAIXO     = 4'd4,
      RESP_ALTO      = 4'd5,
      BIT_BAIXO      = 4'd6,
      BIT_ALTO       = 4'd7,
      FIM_BAIXO      = 4'd8,
      FIM            = 4'd9
   } estado_t;
   localparam int ESPERA_US     = 30;
   localparam int RESP_BAIXO_US = 80;
   localparam int RESP_ALTO_US  = 80;
   localparam int BIT_BAIXO_US  = 50;
   localparam int BIT0_ALTO_US  = 26;
   localparam int BIT1_ALTO_US  = 70;
   localparam int FIM_BAIXO_US  = 50;
   localparam int FRAME_BITS    = 40;
   function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
      return a + b + c + d;
   endfunction
endpackage

// File: rtl/dht11_emulador_sincronizador.sv
// sincronizador_dht: 2-flop synchronizer for the DHT11 line with rise/fall pulses.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : raw line
//   bus_s        : synchronized line (resets to released/high)
//   sobe, desce  : one-cycle pulses on the first cycle bus_s is 1 / 0
module sincronizador_dht
   import dht11_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic bus,
   output logic bus_s,
   output logic sobe,
   output logic desce
);
   logic bus_m, bus_d;
   always_ff @(posedge clock) begin
      if (reset) begin
         bus_m <= 1'b1;
         bus_s <= 1'b1;
         bus_d <= 1'b1;
      end else begin
         bus_m <= bus;
         bus_s <= bus_m;
         bus_d <= bus_s;
      end
   end
   assign sobe  = bus_s & ~bus_d;
   assign desce = ~bus_s & bus_d;
endmodule

// File: rtl/dht11_emulador.sv
// dht11_emulador: sensor-side DHT11 responder; answers a host start pulse with a 40-bit frame.
//   clock, reset          : system clock, synchronous active-high reset
//   habilita              : start pulses accepted only when 1 (checked while idle)
//   umidade_*/temperatura_*: data bytes, snapshotted when the host releases the line
//   injeta_erro           : only with DHT11_EMU_ERRO_CHECKSUM_EN; flips CS bit 0 at the snapshot
//   dht_bus               : open-drain line, driven 0 or Z
//   ocupado, pronto       : response in progress / one-cycle end-of-frame pulse
//   db_estado             : current state code
module dht11_emulador
   import dht11_pkg::*;
#(
   parameter int CLK_POR_US   = 50,
   parameter int START_MIN_US = 10000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [7:0] umidade_int,
   input  logic [7:0] umidade_dec,
   input  logic [7:0] temperatura_int,
   input  logic [7:0] temperatura_dec,
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
   input  logic       injeta_erro,
`endif
   inout  wire        dht_bus,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);
   localparam int LIMIAR = START_MIN_US * CLK_POR_US;
   // wide enough for both the start threshold and the longest response phase
   localparam int MAIOR  = (LIMIAR > RESP_BAIXO_US * CLK_POR_US) ? LIMIAR : RESP_BAIXO_US * CLK_POR_US;
   localparam int TW     = $clog2(MAIOR + 1);
   estado_t estado, nxt;
   logic [TW-1:0] cnt, dur;
   logic [FRAME_BITS-1:0] sr;
   logic [5:0] idx;
   logic [7:0] cs;
   logic bus_s, sobe, desce, baixo, fim;
   sincronizador_dht u_sinc (
      .clock(clock),
      .reset(reset),
      .bus  (dht_bus),
      .bus_s(bus_s),
      .sobe (sobe),
      .desce(desce)
   );
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
   assign cs = checksum(umidade_int, umidade_dec, temperatura_int, temperatura_dec) ^ {7'd0, injeta_erro};
`else
   assign cs = checksum(umidade_int, umidade_dec, temperatura_int, temperatura_dec);
`endif
   assign dur = estado == MEDE_START ? TW'(LIMIAR) :
                estado == ESPERA     ? TW'(ESPERA_US * CLK_POR_US) :
                estado == RESP_BAIXO ? TW'(RESP_BAIXO_US * CLK_POR_US) :
                estado == RESP_ALTO  ? TW'(RESP_ALTO_US * CLK_POR_US) :
                estado == BIT_BAIXO  ? TW'(BIT_BAIXO_US * CLK_POR_US) :
                estado == BIT_ALTO   ? (sr[FRAME_BITS-1] ? TW'(BIT1_ALTO_US * CLK_POR_US)
                                                         : TW'(BIT0_ALTO_US * CLK_POR_US)) :
                estado == FIM_BAIXO  ? TW'(FIM_BAIXO_US * CLK_POR_US) : '0;
   assign fim = cnt == dur - 1'b1;
   assign dht_bus = baixo ? 1'b0 : 1'bz;
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= AGUARDA;
         cnt    <= '0;
         sr     <= '0;
         idx    <= '0;
         baixo  <= 1'b0;
      end else begin
         estado <= nxt;
         baixo  <= estado inside {RESP_BAIXO, BIT_BAIXO, FIM_BAIXO};
         // start measurement begins at 1: the falling-edge cycle seen while idle is already low
         cnt    <= (nxt != estado) ? (nxt == MEDE_START ? TW'(1) : '0) : cnt + 1'b1;
         if (estado == AGUARDA_LIBERA && bus_s) begin
            sr  <= {umidade_int, umidade_dec, temperatura_int, temperatura_dec, cs};
            idx <= '0;
         end else if (estado == BIT_ALTO && fim) begin
            sr  <= {sr[FRAME_BITS-2:0], 1'b0};
            idx <= idx + 1'b1;
         end
      end
   end
   always_comb begin
      nxt       = estado;
      ocupado   = estado inside {ESPERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO, FIM_BAIXO};
      pronto    = estado == FIM;
      db_estado = estado;
      case (estado)
         AGUARDA:        nxt = (desce && habilita) ? MEDE_START : AGUARDA;
         MEDE_START:     nxt = sobe ? AGUARDA : fim ? AGUARDA_LIBERA : MEDE_START;
         AGUARDA_LIBERA: nxt = bus_s ? ESPERA : AGUARDA_LIBERA;
         ESPERA:         nxt = fim ? RESP_BAIXO : ESPERA;
         RESP_BAIXO:     nxt = fim ? RESP_ALTO : RESP_BAIXO;
         RESP_ALTO:      nxt = fim ? BIT_BAIXO : RESP_ALTO;
         BIT_BAIXO:      nxt = fim ? BIT_ALTO : BIT_BAIXO;
         BIT_ALTO:       nxt = !fim ? BIT_ALTO : (idx == 6'(FRAME_BITS - 1)) ? FIM_BAIXO : BIT_BAIXO;
         FIM_BAIXO:      nxt = fim ? FIM : FIM_BAIXO;
         default:        nxt = AGUARDA;
      endcase
   end
endmodule

// File: tb/tb_dht11_emulador.sv
// tb_dht11_emulador: directed self-checking bench for dht11_emulador (CLK_POR_US=2, START_MIN_US=20).
module tb_dht11_emulador;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic habilita = 1'b1;
   logic host = 1'b0;
   logic [7:0] ui = 8'h00, ud = 8'h00, ti = 8'h00, td = 8'h00;
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
   logic injeta_erro = 1'b0;
`endif
   wire dht_bus;
   logic ocupado, pronto;
   logic [3:0] db_estado;
   int checks = 0;
   int errors = 0;
   int n_pronto = 0;
   assign dht_bus = host ? 1'b0 : 1'bz;
   pullup (dht_bus);
   always #5 clock = ~clock;
   always @(negedge clock) if (pronto === 1'b1) n_pronto++;
   dht11_emulador #(.CLK_POR_US(2), .START_MIN_US(20)) dut (
      .clock          (clock),
      .reset          (reset),
      .habilita       (habilita),
      .umidade_int    (ui),
      .umidade_dec    (ud),
      .temperatura_int(ti),
      .temperatura_dec(td),
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
      .injeta_erro    (injeta_erro),
`endif
      .dht_bus        (dht_bus),
      .ocupado        (ocupado),
      .pronto         (pronto),
      .db_estado      (db_estado)
   );
   task automatic inicio(input int n);
      @(posedge clock);
      #1 host = 1'b1;
      repeat (n) @(posedge clock);
      #1 host = 1'b0;
      @(negedge clock);
   endtask
   task automatic medir(input logic lvl, output int w);
      w = 0;
      while (dht_bus === lvl && w < 1000) begin
         w++;
         @(negedge clock);
      end
   endtask
   task automatic capturar(output logic [39:0] fr, output bit viu, output bit tok);
      int w;
      fr = '0;
      viu = 0;
      tok = 1;
      w = 0;
      while (dht_bus !== 1'b0 && w < 2000) begin
         @(negedge clock);
         w++;
      end
      if (dht_bus !== 1'b0) return;
      viu = 1;
      medir(1'b0, w); if (w != 160) tok = 0;
      medir(1'b1, w); if (w != 160) tok = 0;
      for (int i = 0; i < 40; i++) begin
         medir(1'b0, w); if (w != 100) tok = 0;
         medir(1'b1, w); if (w != 52 && w != 140) tok = 0;
         fr = {fr[38:0], w > 96};
      end
      medir(1'b0, w); if (w != 100) tok = 0;
   endtask
   task automatic vigiar(input int n, output int baixos, output int ocup);
      baixos = 0;
      ocup = 0;
      repeat (n) begin
         @(negedge clock);
         if (dht_bus !== 1'b1) baixos++;
         if (ocupado !== 1'b0) ocup++;
      end
   endtask
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
      checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
      checks++; if (dht_bus !== 1'b1) begin errors++; $display("FAIL reset_bus: got %b expected 1", dht_bus); end
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
   endtask
   task automatic test_frame;
      logic [39:0] fr;
      bit viu, tok;
      int p0;
      ui = 8'h37; ud = 8'h00; ti = 8'h19; td = 8'h05;
      p0 = n_pronto;
      inicio(50);
      repeat (10) @(negedge clock);
      checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL frame_ocupado: got %b expected 1", ocupado); end
      checks++; if (db_estado !== 4'd3) begin errors++; $display("FAIL frame_espera: got %0d expected 3", db_estado); end
      capturar(fr, viu, tok);
      checks++; if (viu !== 1'b1) begin errors++; $display("FAIL frame_resposta: got %b expected 1", viu); end
      checks++; if (fr !== 40'h3700190555) begin errors++; $display("FAIL frame_dados: got %h expected 3700190555", fr); end
      checks++; if (tok !== 1'b1) begin errors++; $display("FAIL frame_tempos: got %b expected 1", tok); end
      repeat (3) @(negedge clock);
      checks++; if (n_pronto - p0 !== 1) begin errors++; $display("FAIL frame_pronto: got %0d expected 1", n_pronto - p0); end
      checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL frame_estado_final: got %0d expected 0", db_estado); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL frame_ocupado_final: got %b expected 0", ocupado); end
   endtask
   task automatic test_short_start;
      int b, o;
      inicio(38);
      vigiar(300, b, o);
      checks++; if (b !== 0) begin errors++; $display("FAIL curto19_bus: got %0d low cycles expected 0", b); end
      checks++; if (o !== 0) begin errors++; $display("FAIL curto19_ocupado: got %0d busy cycles expected 0", o); end
      checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL curto19_estado: got %0d expected 0", db_estado); end
      inicio(39);
      vigiar(300, b, o);
      checks++; if (b !== 0) begin errors++; $display("FAIL curto39_bus: got %0d low cycles expected 0", b); end
      checks++; if (o !== 0) begin errors++; $display("FAIL curto39_ocupado: got %0d busy cycles expected 0", o); end
   endtask
   task automatic test_habilita;
      logic [39:0] fr;
      bit viu, tok;
      int b, o;
      ui = 8'h37; ud = 8'h00; ti = 8'h19; td = 8'h05;
      habilita = 1'b0;
      inicio(50);
      vigiar(300, b, o);
      checks++; if (b !== 0) begin errors++; $display("FAIL hab0_bus: got %0d low cycles expected 0", b); end
      checks++; if (o !== 0) begin errors++; $display("FAIL hab0_ocupado: got %0d busy cycles expected 0", o); end
      habilita = 1'b1;
      inicio(40);
      capturar(fr, viu, tok);
      checks++; if (viu !== 1'b1) begin errors++; $display("FAIL hab1_resposta: got %b expected 1", viu); end
      checks++; if (fr !== 40'h3700190555) begin errors++; $display("FAIL hab1_dados: got %h expected 3700190555", fr); end
      checks++; if (tok !== 1'b1) begin errors++; $display("FAIL hab1_tempos: got %b expected 1", tok); end
      repeat (5) @(negedge clock);
   endtask
   task automatic test_reset_mid;
      logic [39:0] fr;
      bit viu, tok;
      int quedas, t;
      logic ant;
      ui = 8'h37; ud = 8'h00; ti = 8'h19; td = 8'h05;
      inicio(50);
      quedas = 0; t = 0; ant = 1'b1;
      while (quedas < 14 && t < 20000) begin
         @(negedge clock);
         t++;
         if (ant === 1'b1 && dht_bus === 1'b0) quedas++;
         ant = dht_bus;
      end
      repeat (10) @(negedge clock);
      checks++; if (dht_bus !== 1'b0) begin errors++; $display("FAIL rstmeio_bit12_baixo: got %b expected 0", dht_bus); end
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checks++; if (dht_bus !== 1'b1) begin errors++; $display("FAIL rstmeio_bus: got %b expected 1", dht_bus); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rstmeio_ocupado: got %b expected 0", ocupado); end
      checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL rstmeio_estado: got %0d expected 0", db_estado); end
      #1 reset = 1'b0;
      repeat (5) @(negedge clock);
      inicio(50);
      capturar(fr, viu, tok);
      checks++; if (fr !== 40'h3700190555) begin errors++; $display("FAIL rstmeio_dados: got %h expected 3700190555", fr); end
      checks++; if (tok !== 1'b1) begin errors++; $display("FAIL rstmeio_tempos: got %b expected 1", tok); end
      repeat (5) @(negedge clock);
   endtask
   task automatic test_snapshot;
      logic [39:0] fr;
      bit viu, tok;
      ui = 8'h12; ud = 8'h34; ti = 8'h56; td = 8'h78;
      inicio(50);
      repeat (10) @(negedge clock);
      ui = 8'hFF; ud = 8'hFF; ti = 8'hFF; td = 8'hFF;
      capturar(fr, viu, tok);
      checks++; if (fr !== 40'h1234567814) begin errors++; $display("FAIL snapshot_dados: got %h expected 1234567814", fr); end
      repeat (5) @(negedge clock);
      inicio(50);
      capturar(fr, viu, tok);
      checks++; if (fr !== 40'hFFFFFFFFFC) begin errors++; $display("FAIL wrap_dados: got %h expected FFFFFFFFFC", fr); end
      checks++; if (tok !== 1'b1) begin errors++; $display("FAIL wrap_tempos: got %b expected 1", tok); end
      repeat (5) @(negedge clock);
   endtask
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
   task automatic test_erro_checksum;
      logic [39:0] fr;
      bit viu, tok;
      ui = 8'h37; ud = 8'h00; ti = 8'h19; td = 8'h05;
      injeta_erro = 1'b1;
      inicio(50);
      repeat (10) @(negedge clock);
      injeta_erro = 1'b0;
      capturar(fr, viu, tok);
      checks++; if (fr !== 40'h3700190554) begin errors++; $display("FAIL erro_cs_dados: got %h expected 3700190554", fr); end
      repeat (5) @(negedge clock);
   endtask
`endif
   initial begin
      test_reset;
      test_frame;
      test_short_start;
      test_habilita;
      test_reset_mid;
      test_snapshot;
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
      test_erro_checksum;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
